// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer: turns each stored one-hot move into a horizontal and a
// vertical robot command, with UART pass-through in IDLE. Define TOUR_CMD_WDOG_EN for the MV-state watchdog.
module tour_cmd_seq #(
  parameter int         NUM_MOVES = 24,
  parameter int         IDX_W     = $clog2(NUM_MOVES),
  parameter int         WDOG_CYC  = 2**20,
  parameter logic [7:0] HDG_N     = 8'h00,
  parameter logic [7:0] HDG_E     = 8'hBF,
  parameter logic [7:0] HDG_S     = 8'h7F,
  parameter logic [7:0] HDG_W     = 8'h3F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [IDX_W-1:0] mv_indx,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_done,
  output logic [1:0]       tour_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_L1_LOAD = 3'd2,
    S_L1_MV   = 3'd3,
    S_L2_LOAD = 3'd4,
    S_L2_MV   = 3'd5
  } state_t;

  localparam logic [3:0]       OP_H      = 4'b0010;
  localparam logic [3:0]       OP_V      = 4'b0011;
  localparam logic [1:0]       ERR_NONE  = 2'd0;
  localparam logic [1:0]       ERR_MOVE  = 2'd1;
  localparam logic [1:0]       ERR_WDOG  = 2'd2;
  localparam logic [7:0]       RESP_UART = 8'hA5;
  localparam logic [7:0]       RESP_TOUR = 8'h5A;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MOVES - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_indx;
  logic [15:0]      r_cmd;
  logic             r_cmd_rdy;
  logic             r_done;
  logic [1:0]       r_err;
  logic [7:0]       r_move;
  logic             w_in_mv;
  logic             w_wdog_exp;

  function automatic logic is_one_hot(input logic [7:0] m);
    return (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [15:0] horiz_cmd(input logic [7:0] m);
    case (m)
      8'h01, 8'h10: horiz_cmd = {OP_H, HDG_W, 4'd1};
      8'h02, 8'h20: horiz_cmd = {OP_H, HDG_E, 4'd1};
      8'h04, 8'h08: horiz_cmd = {OP_H, HDG_W, 4'd2};
      8'h40, 8'h80: horiz_cmd = {OP_H, HDG_E, 4'd2};
      default:      horiz_cmd = {OP_H, HDG_N, 4'd0};
    endcase
  endfunction

  function automatic logic [15:0] vert_cmd(input logic [7:0] m);
    case (m)
      8'h01, 8'h02: vert_cmd = {OP_V, HDG_N, 4'd2};
      8'h04, 8'h80: vert_cmd = {OP_V, HDG_N, 4'd1};
      8'h08, 8'h40: vert_cmd = {OP_V, HDG_S, 4'd1};
      8'h10, 8'h20: vert_cmd = {OP_V, HDG_S, 4'd2};
      default:      vert_cmd = {OP_V, HDG_N, 4'd0};
    endcase
  endfunction

  assign w_in_mv = (r_state == S_L1_MV) || (r_state == S_L2_MV);

`ifdef TOUR_CMD_WDOG_EN
  localparam int WDOG_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  logic [WDOG_W-1:0] r_wdog;

  assign w_wdog_exp = w_in_mv && (r_wdog == WDOG_W'(WDOG_CYC - 1));

  // Response watchdog: zero outside MV states, so it restarts on every MV entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (w_in_mv && !send_resp && !w_wdog_exp) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end else begin
      r_wdog <= '0;
    end
  end
`else
  assign w_wdog_exp = 1'b0;
`endif

  // Tour sequencer: the move is latched in FETCH so both legs come from one stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_indx    <= '0;
      r_cmd     <= 16'h0000;
      r_cmd_rdy <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= ERR_NONE;
      r_move    <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_rdy <= 1'b0;
          if (start_tour) begin
            r_indx  <= '0;
            r_err   <= ERR_NONE;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (is_one_hot(move)) begin
            r_move    <= move;
            r_cmd     <= horiz_cmd(move);
            r_cmd_rdy <= 1'b1;
            r_state   <= S_L1_LOAD;
          end else begin
            r_err   <= ERR_MOVE;
            r_state <= S_IDLE;
          end
        end
        S_L1_LOAD: begin
          if (clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_state   <= S_L1_MV;
          end
        end
        S_L1_MV: begin
          if (send_resp) begin
            r_cmd     <= vert_cmd(r_move);
            r_cmd_rdy <= 1'b1;
            r_state   <= S_L2_LOAD;
          end else if (w_wdog_exp) begin
            r_err     <= ERR_WDOG;
            r_cmd_rdy <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_L2_LOAD: begin
          if (clr_cmd_rdy) begin
            r_cmd_rdy <= 1'b0;
            r_state   <= S_L2_MV;
          end
        end
        S_L2_MV: begin
          if (send_resp) begin
            if (r_indx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_indx  <= r_indx + IDX_W'(1);
              r_state <= S_FETCH;
            end
          end else if (w_wdog_exp) begin
            r_err     <= ERR_WDOG;
            r_cmd_rdy <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_cmd_rdy <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign tour_busy = (r_state != S_IDLE);
  assign mv_indx   = r_indx;
  assign tour_done = r_done;
  assign tour_err  = r_err;
  assign cmd       = tour_busy ? r_cmd     : cmd_UART;
  assign cmd_rdy   = tour_busy ? r_cmd_rdy : cmd_rdy_UART;
  assign resp      = tour_busy ? RESP_TOUR : RESP_UART;

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
Parametrised successor to the tour command converter. It steps through a stored knight's tour of NUM_MOVES one-hot moves and turns each move into two robot commands. The first leg is a horizontal move and the second is a vertical move with fanfare. The block multiplexes between UART pass-through and tour mode, and adds an early-abort path for invalid moves, done/error status, and an optional response watchdog. It sits between the tour solver/move store and the robot command processor.

Parameters:
NUM_MOVES, 24, number of moves in a tour (24 for a 5x5 board); last index is NUM_MOVES-1
IDX_W, $clog2(NUM_MOVES), width of mv_indx
WDOG_CYC, 2**20, cycles a *_MV state waits for send_resp before timeout (used only with the optional feature)
HDG_N / HDG_E / HDG_S / HDG_W, 8'h00 / 8'hBF / 8'h7F / 8'h3F, heading codes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_tour  in  1  pulse to begin a tour (sampled only in IDLE)
move  in  8  one-hot move at mv_indx (from the move store, combinational read)
cmd_UART  in  16  command from the UART wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy  in  1  command processor has consumed cmd
send_resp  in  1  command processor has finished the move
mv_indx  out  IDX_W  index of the move being executed
cmd  out  16  {opcode[3:0], heading[7:0], squares[3:0]}
cmd_rdy  out  1  cmd valid
resp  out  8  8'hA5 in UART mode, 8'h5A in tour mode
tour_busy  out  1  high in any state other than IDLE
tour_done  out  1  one-cycle pulse when the final leg completes
tour_err  out  2  sticky status: 0 none, 1 invalid move, 2 watchdog timeout; cleared on accepted start_tour

Behaviour:
- Reset: state IDLE, mv_indx 0, tour_err 0, tour_done 0, watchdog 0. In IDLE, cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, resp = 8'hA5. Reset mid-tour aborts immediately to IDLE.
- States: IDLE, FETCH, L1_LOAD, L1_MV, L2_LOAD, L2_MV.
- IDLE: start_tour moves to FETCH, clears mv_indx and tour_err. UART pass-through is active here only.
- FETCH (1 cycle): check that move is exactly one-hot.
  - Not one-hot: set tour_err=1 and go to IDLE; no cmd_rdy is issued.
  - One-hot: go to L1_LOAD.
- L1_LOAD: cmd_rdy=1 with the horizontal leg; on clr_cmd_rdy go to L1_MV.
- L1_MV: on send_resp go to L2_LOAD.
- L2_LOAD: cmd_rdy=1 with the vertical leg; on clr_cmd_rdy go to L2_MV.
- L2_MV: on send_resp:
  - If mv_indx==NUM_MOVES-1: pulse tour_done and go to IDLE. mv_indx holds its value.
  - Otherwise: increment mv_indx and go to FETCH.
- Latency: start_tour at cycle N gives cmd_rdy high at N+2. send_resp in L2_MV at cycle M gives the next cmd_rdy at M+2.
- Horizontal leg, opcode 4'b0010:
  - bit0/4: W,1
  - bit1/5: E,1
  - bit2/3: W,2
  - bit6/7: E,2
- Vertical leg, opcode 4'b0011 (fanfare):
  - bit0/1: N,2
  - bit2/7: N,1
  - bit3/6: S,1
  - bit4/5: S,2
- During a tour, cmd and cmd_rdy come from the sequencer. cmd_UART and cmd_rdy_UART are ignored, and resp = 8'h5A.
- Ignored events:
  - clr_cmd_rdy outside *_LOAD states.
  - send_resp outside *_MV states.
  - start_tour while busy.
  - If clr_cmd_rdy and send_resp arrive together in a LOAD state, only clr_cmd_rdy is acted on.
- cmd holds its value throughout each LOAD/MV pair.
- mv_indx never wraps: the increment is suppressed at NUM_MOVES-1.

Optional Feature:
Macro TOUR_CMD_WDOG_EN.
- Defined: a counter clears on entry to each *_MV state and counts while waiting there. On reaching WDOG_CYC-1 without send_resp, set tour_err=2, drop cmd_rdy, and go to IDLE. If send_resp arrives in the same cycle as expiry, send_resp wins.
- Undefined: no counter, tour_err never equals 2, and *_MV states wait indefinitely.

Test Plan:
1. Reset, then drive cmd_UART=16'h1234 with cmd_rdy_UART=1 -> cmd=16'h1234, cmd_rdy=1, resp=8'hA5, tour_busy=0.
2. start_tour with move=8'h01 at every index, NUM_MOVES=24, immediate handshakes -> each index emits 16'h23F1 then 16'h3002; mv_indx runs 0..23; tour_done pulses once; resp=8'h5A while busy.
3. move=8'h40 -> 16'h2BF2 then 16'h37F1. move=8'h10 -> 16'h23F1 then 16'h37F2.
4. move=8'h03 at index 5 -> tour_err=1 after FETCH; IDLE with mv_indx=5; no cmd_rdy issued for index 5. A following start_tour clears tour_err and mv_indx.
5. start_tour pulsed during L1_MV, and send_resp during L1_LOAD -> both ignored; state and mv_indx unchanged. Assert rst in L2_MV -> IDLE, mv_indx=0 asynchronously.
6. With TOUR_CMD_WDOG_EN and WDOG_CYC=16, withhold send_resp in L1_MV -> tour_err=2 and IDLE after 16 cycles. With send_resp on the expiry cycle -> no error and the tour continues.
